// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_arb_pkg;

    localparam int BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        TURN
    } state_t;

    typedef enum logic {
        REQ_FETCH,
        REQ_LD
    } req_id_t;

endpackage

// File: rtl/imem_arb_grant.sv
// Grant selection between fetch and loader. Fixed priority (loader first) by default;
// defining IMEM_ARB_RR_EN switches to round-robin with a last-granted pointer.
module imem_arb_grant
    import imem_arb_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic fire,
`endif
    input  logic fetch_valid,
    input  logic ld_valid,
    output logic grant_fetch,
    output logic grant_ld
);

`ifdef IMEM_ARB_RR_EN
    req_id_t last;

    // Pointer toggles on every handshake; resetting to FETCH makes the loader win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= REQ_FETCH;
        end else if (fire) begin
            last <= (last == REQ_LD) ? REQ_FETCH : REQ_LD;
        end
    end

    always_comb begin
        grant_ld    = ld_valid && !(fetch_valid && (last == REQ_LD));
        grant_fetch = fetch_valid && !grant_ld;
    end
`else
    assign grant_ld    = ld_valid;
    assign grant_fetch = fetch_valid && !ld_valid;
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Serializes fetch reads and loader reads/writes onto one tri-state memory port.
// Optional round-robin grant is enabled by defining IMEM_ARB_RR_EN.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                  fetch_ready_o,
    output logic                  fetch_rvalid_o,
    output logic [BUS_WIDTH-1:0]  fetch_rdata_o,
    input  logic                  ld_valid_i,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [BUS_WIDTH-1:0]  ld_wdata_i,
    output logic                  ld_ready_o,
    output logic                  ld_rvalid_o,
    output logic [BUS_WIDTH-1:0]  ld_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    inout  tri   [BUS_WIDTH-1:0]  mem_bus_io
);

    state_t                 state;
    req_id_t                id_q;
    logic [BUS_WIDTH-1:0]   wdata_q;
    logic                   grant_fetch;
    logic                   grant_ld;
    logic                   fire;

    imem_arb_grant u_grant (
`ifdef IMEM_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .fire        (fire),
`endif
        .fetch_valid (fetch_valid_i),
        .ld_valid    (ld_valid_i),
        .grant_fetch (grant_fetch),
        .grant_ld    (grant_ld)
    );

    assign fetch_ready_o = (state == IDLE) && grant_fetch;
    assign ld_ready_o    = (state == IDLE) && grant_ld;
    assign fire          = fetch_ready_o || ld_ready_o;

    // Driven only from the registered write enable, so the bus releases as soon as reset hits.
    assign mem_bus_io = mem_we_o ? wdata_q : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            id_q           <= REQ_FETCH;
            wdata_q        <= '0;
            mem_addr_o     <= '0;
            mem_re_o       <= 1'b0;
            mem_we_o       <= 1'b0;
            fetch_rvalid_o <= 1'b0;
            fetch_rdata_o  <= '0;
            ld_rvalid_o    <= 1'b0;
            ld_rdata_o     <= '0;
        end else begin
            fetch_rvalid_o <= 1'b0;
            ld_rvalid_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        if (grant_ld) begin
                            id_q       <= REQ_LD;
                            mem_addr_o <= ld_addr_i;
                            wdata_q    <= ld_wdata_i;
                            if (ld_we_i) begin
                                state    <= WRITE;
                                mem_we_o <= 1'b1;
                            end else begin
                                state    <= READ;
                                mem_re_o <= 1'b1;
                            end
                        end else begin
                            id_q       <= REQ_FETCH;
                            mem_addr_o <= fetch_addr_i;
                            state      <= READ;
                            mem_re_o   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_re_o <= 1'b0;
                    state    <= IDLE;
                    if (id_q == REQ_LD) begin
                        ld_rdata_o  <= mem_bus_io;
                        ld_rvalid_o <= 1'b1;
                    end else begin
                        fetch_rdata_o  <= mem_bus_io;
                        fetch_rvalid_o <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_we_o <= 1'b0;
                    state    <= TURN;
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    mem_re_o <= 1'b0;
                    mem_we_o <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus random transactions
// checked against a transaction-level memory and grant-order model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        ld_valid;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ready;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    tri   [31:0] mem_bus;

    logic [31:0] mem [0:255];
    logic [31:0] model [0:255];
    logic        clr;
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int total = 0;
    int bad = 0;
    int n_grants = 0;
    bit ef, el;

    imem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid_i  (fetch_valid),
        .fetch_addr_i   (fetch_addr),
        .fetch_ready_o  (fetch_ready),
        .fetch_rvalid_o (fetch_rvalid),
        .fetch_rdata_o  (fetch_rdata),
        .ld_valid_i     (ld_valid),
        .ld_we_i        (ld_we),
        .ld_addr_i      (ld_addr),
        .ld_wdata_i     (ld_wdata),
        .ld_ready_o     (ld_ready),
        .ld_rvalid_o    (ld_rvalid),
        .ld_rdata_o     (ld_rdata),
        .mem_addr_o     (mem_addr),
        .mem_re_o       (mem_re),
        .mem_we_o       (mem_we),
        .mem_bus_io     (mem_bus)
    );

    always #5 clk = ~clk;

    // Word-addressed memory: drives the bus while read-enabled, commits writes on the edge.
    assign mem_bus = mem_re ? mem[mem_addr[9:2]] : 32'bz;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_bus;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Which requester wins when both are valid, given grants so far since reset.
    function automatic bit ld_first();
`ifdef IMEM_ARB_RR_EN
        return (n_grants % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "/fetch_ready"}, fetch_ready, 0);
        check({tag, "/fetch_rvalid"}, fetch_rvalid, 0);
        check({tag, "/fetch_rdata"}, fetch_rdata, 0);
        check({tag, "/ld_ready"}, ld_ready, 0);
        check({tag, "/ld_rvalid"}, ld_rvalid, 0);
        check({tag, "/ld_rdata"}, ld_rdata, 0);
        check({tag, "/mem_addr"}, mem_addr, 0);
        check({tag, "/mem_re"}, mem_re, 0);
        check({tag, "/mem_we"}, mem_we, 0);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pre_en   = 1'b1;
        pre_idx  = addr[9:2];
        pre_data = data;
        model[addr[9:2]] = data;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Runs one fetch and/or loader request to completion, checking every cycle against
    // the expected grant, memory strobes, bus value and read-data pulses.
    task automatic run_txn(input bit f_en, input bit l_en, input bit l_we,
                           input logic [31:0] fa, input logic [31:0] la,
                           input logic [31:0] lw, input string tag);
        bit f_pend = f_en;
        bit l_pend = l_en;
        bit xf, xl;
        int f_rv = -1, l_rv = -1, re_at = -1, we_at = -1, free_at = 0, cyc = 0;
        logic [31:0] f_exp = '0, l_exp = '0, a_exp = '0;
        fetch_valid = f_en;
        fetch_addr  = fa;
        ld_valid    = l_en;
        ld_we       = l_we;
        ld_addr     = la;
        ld_wdata    = lw;
        while ((f_pend || l_pend || cyc <= f_rv || cyc <= l_rv || cyc < free_at) && cyc < 16) begin
            @(negedge clk);
            xf = 1'b0;
            xl = 1'b0;
            if (cyc >= free_at) begin
                if (l_pend && (!f_pend || ld_first())) xl = 1'b1;
                else xf = f_pend;
            end
            check({tag, "/fetch_ready"}, fetch_ready, xf);
            check({tag, "/ld_ready"}, ld_ready, xl);
            check({tag, "/mem_re"}, mem_re, cyc == re_at);
            check({tag, "/mem_we"}, mem_we, cyc == we_at);
            if (cyc == re_at || cyc == we_at) check({tag, "/mem_addr"}, mem_addr, a_exp);
            if (cyc == we_at) check({tag, "/bus_wdata"}, mem_bus, lw);
            check({tag, "/fetch_rvalid"}, fetch_rvalid, cyc == f_rv);
            if (cyc == f_rv) check({tag, "/fetch_rdata"}, fetch_rdata, f_exp);
            check({tag, "/ld_rvalid"}, ld_rvalid, cyc == l_rv);
            if (cyc == l_rv) check({tag, "/ld_rdata"}, ld_rdata, l_exp);
            @(posedge clk); #1;
            if (xl) begin
                l_pend   = 1'b0;
                ld_valid = 1'b0;
                n_grants++;
                a_exp = la;
                if (l_we) begin
                    model[la[9:2]] = lw;
                    we_at   = cyc + 1;
                    free_at = cyc + 3;
                end else begin
                    l_exp   = model[la[9:2]];
                    re_at   = cyc + 1;
                    l_rv    = cyc + 2;
                    free_at = cyc + 2;
                end
            end
            if (xf) begin
                f_pend      = 1'b0;
                fetch_valid = 1'b0;
                n_grants++;
                a_exp   = fa;
                f_exp   = model[fa[9:2]];
                re_at   = cyc + 1;
                f_rv    = cyc + 2;
                free_at = cyc + 2;
            end
            cyc++;
        end
        check({tag, "/pending_after_budget"}, {31'b0, f_pend | l_pend}, 0);
        fetch_valid = 1'b0;
        ld_valid    = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rf, rl, rw;
        rst         = 1'b1;
        clr         = 1'b1;
        pre_en      = 1'b0;
        pre_idx     = '0;
        pre_data    = '0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        ld_valid    = 1'b0;
        ld_we       = 1'b0;
        ld_addr     = '0;
        ld_wdata    = '0;
        for (int i = 0; i < 256; i++) model[i] = '0;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        clr = 1'b0;
        rst = 1'b0;
        n_grants = 0;
        @(negedge clk);
        check_all_zero("after_reset");
        @(posedge clk); #1;

        // Fetch read of a preloaded word
        preload(32'h10, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, "fetch_rd");

        // Loader write and a fetch read of the same word, both requesting together
        run_txn(1'b1, 1'b1, 1'b1, 32'h20, 32'h20, 32'h12345678, "wr_then_rd");

        // Loader read: only the loader pulse may appear
        preload(32'h40, 32'hA5A55A5A);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, "ld_rd");

        // Both valid continuously for six grants
        fetch_valid = 1'b1;
        fetch_addr  = 32'h10;
        ld_valid    = 1'b1;
        ld_we       = 1'b0;
        ld_addr     = 32'h40;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            el = ((c % 2) == 0) && ld_first();
            ef = ((c % 2) == 0) && !el;
            check("contend/ld_ready", ld_ready, el);
            check("contend/fetch_ready", fetch_ready, ef);
            @(posedge clk); #1;
            if (el || ef) n_grants++;
        end
        fetch_valid = 1'b0;
        ld_valid    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during a write: strobe must drop at once and the word must stay unchanged
        preload(32'h30, 32'h0);
        ld_valid = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 32'h30;
        ld_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("rst_wr/ld_ready", ld_ready, 1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        check("rst_wr/we_before", mem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_wr/we_dropped", mem_we, 0);
        check_all_zero("rst_wr");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_grants = 0;
        check("rst_wr/mem_unchanged", mem[8'h0C], 0);
        @(negedge clk);
        check_all_zero("rst_wr_release");
        @(posedge clk); #1;

        // Idle with no requests
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle/mem_re", mem_re, 0);
            check("idle/mem_we", mem_we, 0);
            check("idle/fetch_rvalid", fetch_rvalid, 0);
            check("idle/ld_rvalid", ld_rvalid, 0);
        end
        @(posedge clk); #1;

        // Random transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            rf = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            if (!rf && !rl) rl = 1'b1;
            ra = 32'($urandom_range(0, 15)) << 2;
            rb = 32'($urandom_range(0, 15)) << 2;
            run_txn(rf, rl, rw, ra, rb, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester controller for the instruction memory's shared address/read-enable/write-enable/tri-state data port. Serializes CPU fetch reads and loader/debug reads and writes onto the single memory port. Owns bus direction and inserts a turnaround cycle after every write. Sits between the fetch stage and the loader on one side and the instruction memory on the other.

## Interface
- ADDR_WIDTH, 32, byte-address width forwarded unchanged to the memory.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_valid_i  in  1  fetch read request.
- fetch_addr_i  in  ADDR_WIDTH  fetch address.
- fetch_ready_o  out  1  fetch request accepted this cycle.
- fetch_rvalid_o  out  1  one-cycle pulse; fetch_rdata_o valid.
- fetch_rdata_o  out  32  fetch read data.
- ld_valid_i  in  1  loader request.
- ld_we_i  in  1  loader request is a write (1) or a read (0).
- ld_addr_i  in  ADDR_WIDTH  loader address.
- ld_wdata_i  in  32  loader write data.
- ld_ready_o  out  1  loader request accepted this cycle.
- ld_rvalid_o  out  1  one-cycle pulse for a loader read; ld_rdata_o valid.
- ld_rdata_o  out  32  loader read data.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_re_o  out  1  memory read enable; memory drives the bus while high.
- mem_we_o  out  1  memory write enable.
- mem_bus_io  inout  32 (tri)  shared data bus; this block drives it only while mem_we_o=1, otherwise 'z.

## Operation
- FSM states: IDLE, READ, WRITE, TURN.
- IDLE:
  - Grant logic picks at most one valid requester.
  - The matching ready output is asserted combinationally in the same cycle.
  - On the handshake edge, address, write data, requester id and op are latched.
  - Next state is READ or WRITE.
- READ (1 cycle):
  - mem_re_o=1; mem_addr_o = latched address.
  - mem_bus_io is sampled into the read-data register at the end of the cycle.
  - Next state: IDLE.
- WRITE (1 cycle):
  - mem_we_o=1; the bus is driven with the latched data; the memory commits on the closing edge.
  - Next state: TURN. No write acknowledge is produced; the handshake is the only completion.
- TURN (1 cycle): bus is 'z, re=we=0, no grant. Next state: IDLE.
- Ready is never asserted outside IDLE. A requester holds its valid, address and data until ready.
- A requester may withdraw valid before ready; nothing is latched in that case.
- Grant policy (default, fixed priority): the loader beats fetch.
- Read data registers hold their last value between pulses.
- Reset (asynchronous):
  - State → IDLE; all outputs 0; bus 'z; read-data registers 0.
  - A WRITE in progress is aborted: mem_we_o falls immediately, and no write may land if reset is asserted before the closing edge.
  - Any pending rvalid is dropped.

## Timing
- Read: handshake at edge N → mem_re_o high during cycle N+1 → rvalid pulse and rdata in cycle N+2. Latency is 2 cycles.
- Write: handshake at edge N → mem_we_o high during cycle N+1 → TURN in N+2 → next grant possible in cycle N+3.
- Peak throughput:
  - Back-to-back reads: one every 2 cycles.
  - Write then any request: one every 3 cycles.
- mem_re_o and mem_we_o are never high together. The bus is never driven by this block while mem_re_o=1.
- Outputs mem_* are registered from the FSM and latched request; there is no combinational path from request inputs to them.

## Configuration
- IMEM_ARB_RR_EN defined:
  - Grant is round-robin; a last-granted pointer flips on each handshake.
  - With both requesters continuously valid, grants alternate loader, fetch, loader, …; the loader is first after reset.
- IMEM_ARB_RR_EN undefined: fixed priority, loader first. Fetch can starve while the loader holds valid.

## Structure
- Package imem_arb_pkg:
  - state enum (IDLE/READ/WRITE/TURN);
  - requester-id enum (REQ_FETCH, REQ_LD);
  - constant BUS_WIDTH=32.
- Sub-module imem_arb_grant: combinational grant plus the round-robin pointer register (pointer only when IMEM_ARB_RR_EN).
- Top: FSM, request latch, tri-state driver, read-data capture.

## Test plan
- Fetch read 0x10 with memory word 0x10 = 0xDEADBEEF:
  - fetch_ready_o=1 in cycle 0.
  - mem_re_o=1 with mem_addr_o=0x10 in cycle 1.
  - fetch_rvalid_o=1 with 0xDEADBEEF in cycle 2.
- Loader write 0x20 ← 0x12345678, then fetch read 0x20:
  - WRITE in cycle 1, TURN in cycle 2.
  - Fetch granted in cycle 3; rvalid in cycle 5 with 0x12345678.
- Both valid continuously for 6 grants:
  - Without the macro: 6 loader grants, fetch_ready_o stays 0.
  - With IMEM_ARB_RR_EN: grant order L, F, L, F, L, F.
- Reset asserted mid-WRITE (addr 0x30, data 0xCAFEF00D, memory previously 0): mem_we_o drops the same cycle, memory 0x30 remains 0, and all outputs read 0.
- Idle with no requests: bus 'z, mem_re_o=mem_we_o=0, no rvalid pulses over 20 cycles.
- Loader read 0x40: ld_rvalid_o pulses 2 cycles after the handshake, and fetch_rvalid_o stays 0 throughout.
